// File: rtl/deserializer_rx_if.sv
// Serial-in / parallel-out bundle for deserializer_rx.
// master = the receiver itself, slave = the serial source plus the parallel consumer.
interface deserializer_rx_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             ser_data;
  logic             ser_valid;
  logic             ser_sof;
  logic             rx_disable;
  logic [WIDTH-1:0] par_data;
  logic             par_valid;
  logic             par_ready;
  logic [4:0]       bit_count;
  logic             frame_err;
  logic             overrun;

  modport master (
    input  ser_data, ser_valid, ser_sof, rx_disable, par_ready,
    output par_data, par_valid, bit_count, frame_err, overrun
  );

  modport slave (
    output ser_data, ser_valid, ser_sof, rx_disable, par_ready,
    input  par_data, par_valid, bit_count, frame_err, overrun
  );
endinterface

// File: rtl/deserializer_rx.sv
// Serial-to-parallel receiver: frames words on SOF, assembles WIDTH bits and
// hands them to a one-word valid/ready holding register, flagging framing errors and overruns.
module deserializer_rx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               resetN,
  deserializer_rx_if.master  bus
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_count_q, bit_count_d;
  logic [WIDTH-1:0]   par_data_q, par_data_d;
  logic               par_valid_q, par_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;

  logic               acc_c;
  logic               word_done_c;
  logic [IDX_W-1:0]   first_pos_c;
  logic [IDX_W-1:0]   pos_c;

  // Next-state, shift-register and hand-off logic.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_count_d = bit_count_q;
    par_data_d  = par_data_q;
    par_valid_d = par_valid_q && !bus.par_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    word_done_c = 1'b0;

    acc_c       = bus.ser_valid && !bus.rx_disable;
    first_pos_c = MSB_FIRST ? IDX_W'(WIDTH - 1) : IDX_W'(0);
    pos_c       = MSB_FIRST ? (IDX_W'(WIDTH - 1) - IDX_W'(bit_count_q))
                            : IDX_W'(bit_count_q);

    unique case (state_q)
      IDLE: begin
        // Bits outside a frame are dropped silently until a SOF shows up.
        if (acc_c && bus.ser_sof) begin
          shreg_d              = '0;
          shreg_d[first_pos_c] = bus.ser_data;
          bit_count_d          = CNT_W'(1);
          state_d              = SHIFT;
        end
      end
      SHIFT: begin
        if (acc_c) begin
          if (bus.ser_sof) begin
            // Mid-word SOF: abandon the partial word and restart on this bit.
            frame_err_d          = 1'b1;
            shreg_d              = '0;
            shreg_d[first_pos_c] = bus.ser_data;
            bit_count_d          = CNT_W'(1);
          end else begin
            shreg_d[pos_c] = bus.ser_data;
            if (bit_count_q == CNT_W'(WIDTH - 1)) begin
              word_done_c = 1'b1;
              bit_count_d = '0;
              state_d     = IDLE;
            end else begin
              bit_count_d = bit_count_q + CNT_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A consume on the completing edge frees the register in time for the new word.
    if (word_done_c) begin
      if (!par_valid_q || bus.par_ready) begin
        par_data_d  = shreg_d;
        par_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_count_q <= '0;
      par_data_q  <= '0;
      par_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_count_q <= bit_count_d;
      par_data_q  <= par_data_d;
      par_valid_q <= par_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.par_data  = par_data_q;
  assign bus.par_valid = par_valid_q;
  assign bus.bit_count = bit_count_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_deserializer_rx.sv
// Directed bench for deserializer_rx: an MSB-first and an LSB-first instance driven in lockstep.
module tb_deserializer_rx;

  logic clk;
  logic resetN;
  int   tests;
  int   fails;

  deserializer_rx_if #(.WIDTH(8)) ifa ();
  deserializer_rx_if #(.WIDTH(8)) ifb ();

  deserializer_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk    (clk),
    .resetN (resetN),
    .bus    (ifa)
  );

  deserializer_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk    (clk),
    .resetN (resetN),
    .bus    (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic d, input logic s);
    ifa.ser_valid = v; ifa.ser_data = d; ifa.ser_sof = s;
    ifb.ser_valid = v; ifb.ser_data = d; ifb.ser_sof = s;
  endtask

  task automatic set_ready(input logic r);
    ifa.par_ready = r;
    ifb.par_ready = r;
  endtask

  task automatic set_disable(input logic x);
    ifa.rx_disable = x;
    ifb.rx_disable = x;
  endtask

  // One accepted bit, then check the running count.
  task automatic bit_step(input string tag, input logic d, input logic s, input logic [4:0] exp_cnt);
    drive(1'b1, d, s);
    tick();
    check(tag, 32'(ifa.bit_count), 32'(exp_cnt));
  endtask

  // Full word, first bit flagged SOF, bits sent w[7] first.
  task automatic send_word(input logic [7:0] w, input logic exp_fe, input logic rdy_last);
    for (int i = 0; i < 8; i++) begin
      if (rdy_last && i == 7) set_ready(1'b1);
      drive(1'b1, w[7-i], i == 0);
      tick();
      if (i == 0) check("frame_err_on_first_bit", 32'(ifa.frame_err), 32'(exp_fe));
      if (i == 1) check("frame_err_one_cycle", 32'(ifa.frame_err), 32'h0);
      check("bit_count_in_word", 32'(ifa.bit_count), (i == 7) ? 32'h0 : 32'(i + 1));
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    resetN = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    set_ready(1'b1);
    set_disable(1'b0);
    tick();
    tick();
    check("reset_par_valid", 32'(ifa.par_valid), 32'h0);
    check("reset_par_data", 32'(ifa.par_data), 32'h0);
    check("reset_bit_count", 32'(ifa.bit_count), 32'h0);
    check("reset_frame_err", 32'(ifa.frame_err), 32'h0);
    check("reset_overrun", 32'(ifa.overrun), 32'h0);
    resetN = 1'b0;
    tick();

    // Bits without SOF in IDLE are ignored
    bit_step("idle_ignore_1", 1'b1, 1'b0, 5'd0);
    bit_step("idle_ignore_2", 1'b0, 1'b0, 5'd0);
    check("idle_ignore_no_err", 32'(ifa.frame_err), 32'h0);
    drive(1'b0, 1'b0, 1'b0);
    tick();

    // Test 1: A5, MSB-first and LSB-first both read A5 (palindromic pattern)
    send_word(8'hA5, 1'b0, 1'b0);
    check("t1_valid", 32'(ifa.par_valid), 32'h1);
    check("t1_data_msb", 32'(ifa.par_data), 32'hA5);
    check("t1_data_lsb", 32'(ifb.par_data), 32'hA5);
    tick();
    check("t1_valid_one_cycle", 32'(ifa.par_valid), 32'h0);
    check("t1_data_retained", 32'(ifa.par_data), 32'hA5);

    // Test 2: stall after 4 bits, then a disabled SOF bit is ignored
    bit_step("t2_b0", 1'b1, 1'b1, 5'd1);
    bit_step("t2_b1", 1'b0, 1'b0, 5'd2);
    bit_step("t2_b2", 1'b1, 1'b0, 5'd3);
    bit_step("t2_b3", 1'b0, 1'b0, 5'd4);
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_stall_count", 32'(ifa.bit_count), 32'd4);
    end
    set_disable(1'b1);
    bit_step("t2_disabled", 1'b1, 1'b1, 5'd4);
    check("t2_disabled_no_err", 32'(ifa.frame_err), 32'h0);
    set_disable(1'b0);
    bit_step("t2_b4", 1'b0, 1'b0, 5'd5);
    bit_step("t2_b5", 1'b1, 1'b0, 5'd6);
    bit_step("t2_b6", 1'b0, 1'b0, 5'd7);
    bit_step("t2_b7", 1'b1, 1'b0, 5'd0);
    drive(1'b0, 1'b0, 1'b0);
    check("t2_valid", 32'(ifa.par_valid), 32'h1);
    check("t2_data", 32'(ifa.par_data), 32'hA5);
    tick();

    // Test 3: restart after 5 bits, then 3C
    bit_step("t3_p0", 1'b1, 1'b1, 5'd1);
    for (int i = 1; i < 5; i++) bit_step("t3_partial", 1'b1, 1'b0, 5'(i + 1));
    send_word(8'h3C, 1'b1, 1'b0);
    check("t3_data_msb", 32'(ifa.par_data), 32'h3C);
    check("t3_data_lsb", 32'(ifb.par_data), 32'h3C);
    check("t3_no_overrun", 32'(ifa.overrun), 32'h0);
    tick();

    // Test 4: held word, second word overruns, then consume
    set_ready(1'b0);
    send_word(8'h11, 1'b0, 1'b0);
    check("t4_first_valid", 32'(ifa.par_valid), 32'h1);
    check("t4_first_data", 32'(ifa.par_data), 32'h11);
    send_word(8'h22, 1'b0, 1'b0);
    check("t4_overrun", 32'(ifa.overrun), 32'h1);
    check("t4_data_kept", 32'(ifa.par_data), 32'h11);
    check("t4_data_kept_lsb", 32'(ifb.par_data), 32'h88);
    check("t4_still_valid", 32'(ifa.par_valid), 32'h1);
    tick();
    check("t4_overrun_one_cycle", 32'(ifa.overrun), 32'h0);
    set_ready(1'b1);
    tick();
    check("t4_consumed", 32'(ifa.par_valid), 32'h0);
    check("t4_data_after_consume", 32'(ifa.par_data), 32'h11);

    // Test 5: consume and load on the same edge
    set_ready(1'b0);
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b1);
    check("t5_data", 32'(ifa.par_data), 32'h22);
    check("t5_data_lsb", 32'(ifb.par_data), 32'h44);
    check("t5_valid", 32'(ifa.par_valid), 32'h1);
    check("t5_no_overrun", 32'(ifa.overrun), 32'h0);
    tick();
    check("t5_consumed", 32'(ifa.par_valid), 32'h0);

    // Test 6: reset with a held word and a partial word
    set_ready(1'b0);
    send_word(8'h55, 1'b0, 1'b0);
    bit_step("t6_p0", 1'b1, 1'b1, 5'd1);
    bit_step("t6_p1", 1'b1, 1'b0, 5'd2);
    bit_step("t6_p2", 1'b1, 1'b0, 5'd3);
    bit_step("t6_p3", 1'b1, 1'b0, 5'd4);
    drive(1'b0, 1'b0, 1'b0);
    resetN = 1'b1;
    tick();
    check("t6_rst_valid", 32'(ifa.par_valid), 32'h0);
    check("t6_rst_data", 32'(ifa.par_data), 32'h0);
    check("t6_rst_count", 32'(ifa.bit_count), 32'h0);
    check("t6_rst_err", 32'(ifa.frame_err), 32'h0);
    check("t6_rst_overrun", 32'(ifa.overrun), 32'h0);
    resetN = 1'b0;
    set_ready(1'b1);
    send_word(8'hF0, 1'b0, 1'b0);
    check("t6_valid", 32'(ifa.par_valid), 32'h1);
    check("t6_data_msb", 32'(ifa.par_data), 32'hF0);
    check("t6_data_lsb", 32'(ifb.par_data), 32'h0F);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
